// File: rtl/adc_pkg.sv
// Shared constants and helpers for the ADC-sample chain.
//   SIZE_ADC_DATA    : width of one ADC sample
//   SIZE_FILTER_DATA : width of the shaping-filter internal data path
//   emu_state_t      : pulse-emulator FSM state
//   sat_add          : unsigned add clipped to the all-ones sample value
package adc_pkg;

  localparam int SIZE_ADC_DATA    = 12;
  localparam int SIZE_FILTER_DATA = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } emu_state_t;

  // The sum is formed one bit wider so the carry can select the clip value.
  function automatic logic [SIZE_ADC_DATA-1:0] sat_add(
    input logic [SIZE_ADC_DATA-1:0] a,
    input logic [SIZE_ADC_DATA-1:0] b
  );
    logic [SIZE_ADC_DATA:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SIZE_ADC_DATA] ? {SIZE_ADC_DATA{1'b1}} : s[SIZE_ADC_DATA-1:0];
  endfunction

endpackage

// File: rtl/adc_pulse_emulator.sv
// Synthetic detector-pulse source in ADC sample format.
// Each pulse is a linear rise over 2^r samples up to amplitude A, then an
// exponential tail (tail -= tail>>d per sample), added on top of a live
// baseline and clipped to the sample range. One trigger can be held while a
// pulse is running; further triggers are dropped and counted.
//
// Ports:
//   clk         : sample clock, one sample per cycle
//   reset       : synchronous, active-high
//   trig        : pulse request, sampled every rising edge
//   amplitude   : peak height A, latched at pulse start
//   rise_shift  : r, rise lasts 2^r samples, latched at pulse start
//   decay_shift : d, decay shift, latched at pulse start
//   baseline    : pedestal, used live every cycle
//   output_data : registered sample = sat(baseline + tail)
//   pulse_start : high in the first sample of each pulse
//   busy        : a pulse is in progress
//   drop_cnt    : dropped triggers, saturating at 255
module adc_pulse_emulator
  import adc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trig,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  input  logic [2:0]               rise_shift,
  input  logic [3:0]               decay_shift,
  input  logic [SIZE_ADC_DATA-1:0] baseline,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic                     pulse_start,
  output logic                     busy,
  output logic [7:0]               drop_cnt
);

  localparam int W = SIZE_ADC_DATA;

  emu_state_t   state;
  logic [W-1:0] tail;
  logic [W-1:0] amp_l;
  logic [2:0]   rise_l;
  logic [3:0]   decay_l;
  logic [W-1:0] step;
  logic [7:0]   rise_cnt;    // index of the rise sample currently on the output
  logic         pending;

  emu_state_t   nxt_state;
  logic [W-1:0] nxt_tail;
  logic [7:0]   nxt_rise;
  logic         nxt_pend;
  logic [7:0]   nxt_drop;
  logic         start;
  logic         end_edge;
  logic [W-1:0] decay_amt;
  logic [7:0]   rise_last;
  logic [7:0]   rise_inc;

  assign decay_amt = tail >> decay_l;
  assign rise_last = (8'd1 << rise_l) - 8'd1;
  assign rise_inc  = rise_cnt + 8'd1;
  // The tail has decayed to where the next decrement would be zero: this
  // edge finishes the pulse.
  assign end_edge  = (state == DECAY) && (decay_amt == '0);

  always_comb begin
    nxt_state = state;
    nxt_tail  = tail;
    nxt_rise  = rise_cnt;
    nxt_pend  = pending;
    nxt_drop  = drop_cnt;
    start     = 1'b0;

    case (state)
      IDLE: begin
        nxt_tail = '0;
        if (trig) start = 1'b1;
      end
      RISE: begin
        nxt_rise = rise_inc;
        // Last rise sample lands on A exactly, hiding the truncation in step.
        if (rise_inc == rise_last) begin
          nxt_tail  = amp_l;
          nxt_state = DECAY;
        end else begin
          nxt_tail = tail + step;
        end
      end
      DECAY: begin
        if (end_edge) begin
          nxt_tail  = '0;
          nxt_state = IDLE;
          // A waiting request starts right here, with no idle sample. A
          // fresh trig on this edge stays buffered only if one was already
          // pending (that one is consumed now).
          if (pending || trig) begin
            start    = 1'b1;
            nxt_pend = pending & trig;
          end
        end else begin
          nxt_tail = tail - decay_amt;
        end
      end
      default: begin
        nxt_tail  = '0;
        nxt_state = IDLE;
      end
    endcase

    // Trigger buffering while a pulse is running (end edge handled above).
    if (state != IDLE && !end_edge && trig) begin
      if (!pending)               nxt_pend = 1'b1;
      else if (drop_cnt != 8'hFF) nxt_drop = drop_cnt + 8'd1;
    end

    // New pulse: shape parameters come from the inputs on this edge.
    if (start) begin
      nxt_rise = '0;
      if (rise_shift == 3'd0) begin
        nxt_tail  = amplitude;
        nxt_state = DECAY;
      end else begin
        nxt_tail  = amplitude >> rise_shift;
        nxt_state = RISE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tail        <= '0;
      amp_l       <= '0;
      rise_l      <= '0;
      decay_l     <= '0;
      step        <= '0;
      rise_cnt    <= '0;
      pending     <= 1'b0;
      drop_cnt    <= '0;
      output_data <= '0;
      pulse_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt_state;
      tail        <= nxt_tail;
      rise_cnt    <= nxt_rise;
      pending     <= nxt_pend;
      drop_cnt    <= nxt_drop;
      output_data <= sat_add(baseline, nxt_tail);
      pulse_start <= start;
      busy        <= (nxt_state != IDLE);
      if (start) begin
        amp_l   <= amplitude;
        rise_l  <= rise_shift;
        decay_l <= decay_shift;
        step    <= amplitude >> rise_shift;
      end
    end
  end

endmodule

// File: tb/tb_adc_pulse_emulator.sv
// Bench for adc_pulse_emulator: directed scenarios plus random stimulus,
// all checked against a waveform-level reference model.
module tb_adc_pulse_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig;
  logic [11:0] amplitude;
  logic [2:0]  rise_shift;
  logic [3:0]  decay_shift;
  logic [11:0] baseline;
  logic [11:0] output_data;
  logic        pulse_start;
  logic        busy;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  adc_pulse_emulator dut (
    .clk(clk), .reset(reset), .trig(trig), .amplitude(amplitude),
    .rise_shift(rise_shift), .decay_shift(decay_shift), .baseline(baseline),
    .output_data(output_data), .pulse_start(pulse_start), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a pulse is a precomputed list of tail samples; the
  // edge after its last sample is the end edge.
  int          wave[$];
  int          idx;
  bit          m_act, m_pend, m_ps, m_busy;
  int          m_drop;
  logic [11:0] m_out;

  function automatic void build_wave(int a, int r, int d);
    int st, t;
    wave.delete();
    st = a >> r;
    for (int i = 0; i < (1 << r) - 1; i++) wave.push_back((i + 1) * st);
    wave.push_back(a);
    t = a;
    while ((t >> d) != 0) begin
      t = t - (t >> d);
      wave.push_back(t);
    end
  endfunction

  task automatic m_start();
    build_wave(int'(amplitude), int'(rise_shift), int'(decay_shift));
    idx = 0; m_act = 1; m_ps = 1;
  endtask

  task automatic model_step();
    int sum;
    m_ps = 0;
    if (reset) begin
      m_act = 0; m_pend = 0; m_drop = 0; m_out = '0; m_busy = 0;
    end else begin
      if (!m_act) begin
        if (trig) m_start();
      end else if (idx == wave.size() - 1) begin
        if (m_pend || trig) begin
          m_start();
          m_pend = m_pend && trig;
        end else m_act = 0;
      end else begin
        idx++;
        if (trig) begin
          if (!m_pend) m_pend = 1;
          else if (m_drop < 255) m_drop++;
        end
      end
      sum = int'(baseline) + (m_act ? wave[idx] : 0);
      m_out = (sum > 4095) ? 12'd4095 : 12'(sum);
      m_busy = m_act;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; trig = 0; amplitude = '0; rise_shift = '0; decay_shift = '0;
    baseline = 12'd100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (output_data !== 12'd0 || busy !== 1'b0 || pulse_start !== 1'b0 || drop_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL reset: out=%0d busy=%0b ps=%0b drop=%0d, want 0 0 0 0",
                 output_data, busy, pulse_start, drop_cnt);
      end
    end
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (output_data !== 12'd100 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_baseline: out=%0d busy=%0b, want 100 0", output_data, busy);
      end
    end
  endtask

  task automatic test_single_pulse();
    int exp_seq[6] = '{350, 600, 850, 1100, 975, 866};
    baseline = 12'd100; amplitude = 12'd1000; rise_shift = 3'd2; decay_shift = 4'd3;
    trig = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      trig = 0;
      n_vec++;
      if (output_data !== 12'(exp_seq[i]) || pulse_start !== (i == 0) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL single_shape[%0d]: out=%0d ps=%0b busy=%0b, want %0d %0b 1",
                 i, output_data, pulse_start, busy, exp_seq[i], i == 0);
      end
    end
    for (int i = 0; i < 300 && m_busy; i++) begin
      tick();
      n_vec++;
      if ({output_data, pulse_start, busy, drop_cnt} !== {m_out, m_ps, m_busy, 8'(m_drop)}) begin
        n_err++;
        $display("FAIL single_tail: out=%0d ps=%0b busy=%0b drop=%0d, want %0d %0b %0b %0d",
                 output_data, pulse_start, busy, drop_cnt, m_out, m_ps, m_busy, m_drop);
      end
    end
    n_vec++;
    if (busy !== 1'b0 || output_data !== 12'd100) begin
      n_err++;
      $display("FAIL single_end: busy=%0b out=%0d, want 0 100", busy, output_data);
    end
  endtask

  task automatic test_r0_d0();
    int busy_cycles = 0;
    int exp_seq[3] = '{500, 0, 0};
    baseline = 12'd0; amplitude = 12'd500; rise_shift = 3'd0; decay_shift = 4'd0;
    trig = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      trig = 0;
      if (busy === 1'b1) busy_cycles++;
      n_vec++;
      if (output_data !== 12'(exp_seq[i])) begin
        n_err++;
        $display("FAIL r0d0_out[%0d]: got %0d, want %0d", i, output_data, exp_seq[i]);
      end
    end
    tick();
    if (busy === 1'b1) busy_cycles++;
    n_vec++;
    if (busy_cycles !== 2) begin
      n_err++;
      $display("FAIL r0d0_busy: busy cycles %0d, want 2", busy_cycles);
    end
  endtask

  task automatic test_saturation();
    bit released = 0;
    baseline = 12'd4000; amplitude = 12'd1000; rise_shift = 3'd0; decay_shift = 4'd2;
    trig = 1;
    tick();
    trig = 0;
    n_vec++;
    if (output_data !== 12'd4095 || pulse_start !== 1'b1) begin
      n_err++;
      $display("FAIL sat_first: out=%0d ps=%0b, want 4095 1", output_data, pulse_start);
    end
    for (int i = 0; i < 100 && m_busy; i++) begin
      tick();
      if (output_data < 12'd4095) released = 1;
      n_vec++;
      if ({output_data, pulse_start, busy, drop_cnt} !== {m_out, m_ps, m_busy, 8'(m_drop)}) begin
        n_err++;
        $display("FAIL sat_tail: out=%0d ps=%0b busy=%0b drop=%0d, want %0d %0b %0b %0d",
                 output_data, pulse_start, busy, drop_cnt, m_out, m_ps, m_busy, m_drop);
      end
    end
    n_vec++;
    if (!released) begin
      n_err++;
      $display("FAIL sat_release: output never dropped below 4095");
    end
  endtask

  task automatic test_back_to_back();
    bit saw_idle = 0;
    bit second = 0;
    baseline = 12'd50; amplitude = 12'd800; rise_shift = 3'd1; decay_shift = 4'd2;
    trig = 1;
    tick();
    for (int i = 1; i < 100; i++) begin
      trig = (i == 3 || i == 5 || i == 7);
      tick();
      if (busy !== 1'b1) saw_idle = 1;
      n_vec++;
      if ({output_data, pulse_start, busy, drop_cnt} !== {m_out, m_ps, m_busy, 8'(m_drop)}) begin
        n_err++;
        $display("FAIL b2b_model: out=%0d ps=%0b busy=%0b drop=%0d, want %0d %0b %0b %0d",
                 output_data, pulse_start, busy, drop_cnt, m_out, m_ps, m_busy, m_drop);
      end
      if (pulse_start === 1'b1) begin second = 1; break; end
    end
    trig = 0;
    n_vec++;
    if (!second || saw_idle || busy !== 1'b1 || drop_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL b2b_restart: second=%0b idle_gap=%0b busy=%0b drop=%0d, want 1 0 1 2",
               second, saw_idle, busy, drop_cnt);
    end
    for (int i = 0; i < 200 && m_busy; i++) tick();
    tick();
  endtask

  task automatic test_reset_mid();
    baseline = 12'd10; amplitude = 12'd2000; rise_shift = 3'd0; decay_shift = 4'd4;
    trig = 1;
    tick();
    trig = 0;
    for (int i = 0; i < 3; i++) tick();
    trig = 1;
    tick();
    trig = 0;
    reset = 1;
    tick();
    n_vec++;
    if (output_data !== 12'd0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid: out=%0d busy=%0b drop=%0d, want 0 0 0", output_data, busy, drop_cnt);
    end
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (output_data !== 12'd10 || busy !== 1'b0 || pulse_start !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_after: out=%0d busy=%0b ps=%0b, want 10 0 0",
                 output_data, busy, pulse_start);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      trig        = ($urandom_range(0, 9) == 0);
      amplitude   = 12'($urandom);
      rise_shift  = 3'($urandom);
      decay_shift = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) baseline = 12'($urandom);
      reset       = ($urandom_range(0, 499) == 0);
      tick();
      n_vec++;
      if ({output_data, pulse_start, busy, drop_cnt} !== {m_out, m_ps, m_busy, 8'(m_drop)}) begin
        n_err++;
        $display("FAIL random[%0d]: out=%0d ps=%0b busy=%0b drop=%0d, want %0d %0b %0b %0d",
                 i, output_data, pulse_start, busy, drop_cnt, m_out, m_ps, m_busy, m_drop);
      end
    end
    reset = 0; trig = 0;
  endtask

  initial begin
    m_act = 0; m_pend = 0; m_ps = 0; m_busy = 0; m_drop = 0; m_out = '0; idx = 0;
    test_reset();
    test_single_pulse();
    test_r0_d0();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_pulse_emulator.md
# adc_pulse_emulator

Synthetic detector-pulse source producing an ADC-format sample stream (baseline + linear rise + exponential decay) for the shaping-filter chain. Drives the filters' `input_data` in place of the real ADC for self-test and bench stimulus: it is the producer end of the ADC-sample interface the filters consume. It supports one-deep trigger buffering and counts dropped triggers.

## Interface
- `SIZE_ADC_DATA`, 12, sample width. Taken from the shared package constant.
- `clk`  in  1  sample clock, one sample per cycle.
- `reset`  in  1  synchronous, active-high.
- `trig`  in  1  request a pulse; sampled every rising edge.
- `amplitude`  in  SIZE_ADC_DATA  peak height A, unsigned; latched at pulse start.
- `rise_shift`  in  3  r; rise lasts 2^r samples; latched at pulse start.
- `decay_shift`  in  4  d; per-sample decay tail -= tail>>d; latched at pulse start.
- `baseline`  in  SIZE_ADC_DATA  pedestal, unsigned; used live every cycle.
- `output_data`  out  SIZE_ADC_DATA  registered sample.
- `pulse_start`  out  1  one-cycle strobe, high in the first sample of each pulse.
- `busy`  out  1  state != IDLE.
- `drop_cnt`  out  8  count of dropped triggers; saturates at 255.

## Operation
- Internal registers:
  - `tail` (SIZE_ADC_DATA bits).
  - latched A, r, d.
  - `step` = A >> r.
  - rise counter.
  - `pending` flag.
- FSM states are IDLE, RISE and DECAY.
- IDLE:
  - `tail` = 0.
  - On trig: latch A, r, d. Then `tail` <= step; if r == 0, `tail` <= A instead.
  - Go to RISE (r > 0) or DECAY (r == 0).
- RISE, sample i = 0..2^r-1:
  - `tail` = (i+1)*step.
  - Last sample forces `tail` = A exactly, then DECAY.
- DECAY, each edge:
  - If (tail >> d) != 0: `tail` <= tail - (tail >> d).
  - Otherwise this is the end edge: `tail` <= 0 and go to IDLE.
  - d == 0 gives one sample at 0, then end.
- End edge with a waiting request (`pending` or `trig`): start the new pulse directly (RISE/DECAY as from IDLE, no idle gap). Then `pending` <= pending & trig.
- `trig` while busy, not on the end edge:
  - `pending` clear: set `pending`.
  - `pending` set: drop the trigger and increment `drop_cnt`.
- A pending pulse latches amplitude/shifts at the edge it actually starts, not when requested.
- Output arithmetic:
  - output_data <= sat(baseline + next_tail).
  - Sum is SIZE_ADC_DATA+1 bits; clip to 2^SIZE_ADC_DATA-1.
  - All arithmetic is unsigned; `tail` never underflows.

## Timing
- Reset values:
  - `output_data` = 0, `pulse_start` = 0, `busy` = 0, `drop_cnt` = 0.
  - `tail` = 0, `pending` = 0, state IDLE.
- First edge after reset release with no trig: `output_data` = baseline.
- Reset asserted mid-pulse aborts it and clears `pending` and `drop_cnt` on that edge.
- Latency:
  - `trig` high at edge k (IDLE): `pulse_start` = 1, `busy` = 1 and `output_data` = sat(baseline+step) after edge k.
  - Peak sample appears after edge k+2^r-1.
- `busy` falls after the end edge unless a new pulse starts on it; in that case `busy` stays 1 and `pulse_start` pulses.
- `baseline` changes are reflected in `output_data` one edge later, in any state.

## Structure
- Shared package `adc_pkg`:
  - SIZE_ADC_DATA and SIZE_FILTER_DATA constants.
  - Typedef `emu_state_t` enum {IDLE, RISE, DECAY}.
  - Saturating unsigned add function `sat_add`.
- Single module; no sub-module needed. The FSM, trigger buffer and sample path share one always_ff.

## Test plan
- Reset then idle, baseline = 100 -> `output_data` = 0 during reset, then 100 every cycle, `busy` = 0.
- baseline = 100, A = 1000, r = 2, d = 3, single trig:
  - Rise: 350, 600, 850, 1100.
  - Decay: 975, 866, ...
  - Falls back to 100 (tail reaches 0 once tail < 8).
  - `pulse_start` high only on the 350 sample.
- r = 0, d = 0, A = 500, baseline = 0 -> outputs 500, 0, then idle; `busy` high exactly 2 cycles.
- baseline = 4000, A = 1000, r = 0 -> first sample clipped to 4095; output decays and saturation releases once the sum is ≤ 4095.
- Three trigs during one pulse:
  - First sets `pending`; second and third give `drop_cnt` = 2.
  - Second pulse starts on the end edge with no idle sample and `pulse_start` = 1.
- Reset asserted mid-DECAY with `pending` set -> next edge `output_data` = 0, `busy` = 0, `pending` cleared; no pulse follows.
